// File: rtl/rat_pkg.sv
// Shared definitions for the RAT core: address width, fixed vectors and
// the PC source mux select encoding used by the mux and the control unit.
package rat_pkg;

   localparam int          ADDR_W_DEF    = 10;
   localparam logic [9:0]  INTR_VEC      = 10'h3FF;
   localparam logic [9:0]  RESET_VEC_DEF = 10'h000;

   typedef enum logic [1:0] {
      SEL_IMMED = 2'b00,
      SEL_STACK = 2'b01,
      SEL_INTR  = 2'b10
   } pc_sel_t;

endpackage

// File: rtl/rat_ret_stack.sv
// Hardware return-address LIFO for the RAT program counter stage.
// Holds return addresses for CALL/RET and interrupt entry, exposes the top
// entry to the PC source mux, and keeps sticky overflow/underflow flags.
module rat_ret_stack
   import rat_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DEPTH  = 8
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_push,
   input  logic              i_pop,
   input  logic              i_clr,
   input  logic [ADDR_W-1:0] i_pushVal,
   output logic [ADDR_W-1:0] o_top,
   output logic              o_empty,
   output logic              o_full,
   output logic              o_ovf,
   output logic              o_unf
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = IDX_W + 1;

   logic [CNT_W-1:0]  r_count;
   logic [ADDR_W-1:0] r_entry [DEPTH];
   logic              r_ovf;
   logic              r_unf;

   logic              w_empty;
   logic              w_full;
   logic              w_replace;
   logic              w_doPush;
   logic              w_doPop;
   logic              w_setOvf;
   logic              w_setUnf;
   logic [IDX_W-1:0]  w_topIdx;
   logic [IDX_W-1:0]  w_wrIdx;

   // A push paired with a pop on a non-empty stack rewrites the top in place;
   // on an empty stack the pop is ignored and the push proceeds normally.
   always_comb begin
      w_empty   = (r_count == '0);
      w_full    = (r_count == CNT_W'(DEPTH));
      w_replace = i_push & i_pop & ~w_empty;
      w_doPush  = i_push & ~w_replace & ~w_full;
      w_doPop   = i_pop & ~i_push & ~w_empty;
      w_setOvf  = i_push & ~w_replace & w_full;
      w_setUnf  = i_pop & ~i_push & w_empty;
      w_topIdx  = IDX_W'(r_count - CNT_W'(1));
      w_wrIdx   = w_replace ? w_topIdx : r_count[IDX_W-1:0];
   end

   // Entry storage is never reset; occupancy alone decides what is valid.
   always_ff @(posedge i_clk) begin
      if (w_replace || w_doPush) begin
         r_entry[w_wrIdx] <= i_pushVal;
      end
   end

   // Occupancy count, saturating at 0 and DEPTH through the guards above.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (w_doPush) begin
         r_count <= r_count + CNT_W'(1);
      end else if (w_doPop) begin
         r_count <= r_count - CNT_W'(1);
      end
   end

   // Sticky error flags; a new error in the same cycle beats a clear.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ovf <= 1'b0;
         r_unf <= 1'b0;
      end else begin
         if (w_setOvf) begin
            r_ovf <= 1'b1;
         end else if (i_clr) begin
            r_ovf <= 1'b0;
         end
         if (w_setUnf) begin
            r_unf <= 1'b1;
         end else if (i_clr) begin
            r_unf <= 1'b0;
         end
      end
   end

   // Top-of-stack is driven only from registered state so the mux sees no
   // combinational path back from its own output.
   always_comb begin
      o_top   = w_empty ? '0 : r_entry[w_topIdx];
      o_empty = w_empty;
      o_full  = w_full;
      o_ovf   = r_ovf;
      o_unf   = r_unf;
   end

endmodule

// File: rtl/rat_pc_unit.sv
// Program-counter stage of the RAT core: registers the PC source mux output
// and owns the return-address stack whose top feeds the mux back.
module rat_pc_unit
   import rat_pkg::*;
#(
   parameter int                ADDR_W    = ADDR_W_DEF,
   parameter int                DEPTH     = 8,
   parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(RESET_VEC_DEF)
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic [ADDR_W-1:0] D_IN,
   input  logic              PC_LD,
   input  logic              PC_INC,
   input  logic              PUSH,
   input  logic              PUSH_CUR,
   input  logic              POP,
   input  logic              ERR_CLR,
   output logic [ADDR_W-1:0] PC_COUNT,
   output logic [ADDR_W-1:0] FROM_STACK,
   output logic              STK_EMPTY,
   output logic              STK_FULL,
   output logic              STK_OVF,
   output logic              STK_UNF
);

   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] w_pcPlus1;
   logic [ADDR_W-1:0] w_pushVal;

   // Interrupt entry saves the interrupted PC itself; CALL saves the next one.
   always_comb begin
      w_pcPlus1 = r_pc + ADDR_W'(1);
      w_pushVal = PUSH_CUR ? r_pc : w_pcPlus1;
   end

   // PC register: load beats increment, otherwise hold; increment wraps.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_pc <= RESET_VEC;
      end else if (PC_LD) begin
         r_pc <= D_IN;
      end else if (PC_INC) begin
         r_pc <= w_pcPlus1;
      end
   end

   assign PC_COUNT = r_pc;

   rat_ret_stack #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_stack (
      .i_clk     (CLK),
      .i_rst_n   (RST_N),
      .i_push    (PUSH),
      .i_pop     (POP),
      .i_clr     (ERR_CLR),
      .i_pushVal (w_pushVal),
      .o_top     (FROM_STACK),
      .o_empty   (STK_EMPTY),
      .o_full    (STK_FULL),
      .o_ovf     (STK_OVF),
      .o_unf     (STK_UNF)
   );

endmodule

// File: tb/tb_rat_pc_unit.sv
// Self-checking bench for rat_pc_unit: directed scenarios followed by random
// traffic, all compared against a queue-based model of the PC and stack.
module tb_rat_pc_unit;

   localparam int ADDR_W = 10;
   localparam int DEPTH  = 8;

   logic              CLK;
   logic              RST_N;
   logic [ADDR_W-1:0] D_IN;
   logic              PC_LD;
   logic              PC_INC;
   logic              PUSH;
   logic              PUSH_CUR;
   logic              POP;
   logic              ERR_CLR;
   logic [ADDR_W-1:0] PC_COUNT;
   logic [ADDR_W-1:0] FROM_STACK;
   logic              STK_EMPTY;
   logic              STK_FULL;
   logic              STK_OVF;
   logic              STK_UNF;

   int checks = 0;
   int errors = 0;

   logic [ADDR_W-1:0] mPc;
   logic [ADDR_W-1:0] mStk[$];
   logic              mOvf;
   logic              mUnf;

   rat_pc_unit #(
      .ADDR_W    (ADDR_W),
      .DEPTH     (DEPTH),
      .RESET_VEC (10'h000)
   ) dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .D_IN       (D_IN),
      .PC_LD      (PC_LD),
      .PC_INC     (PC_INC),
      .PUSH       (PUSH),
      .PUSH_CUR   (PUSH_CUR),
      .POP        (POP),
      .ERR_CLR    (ERR_CLR),
      .PC_COUNT   (PC_COUNT),
      .FROM_STACK (FROM_STACK),
      .STK_EMPTY  (STK_EMPTY),
      .STK_FULL   (STK_FULL),
      .STK_OVF    (STK_OVF),
      .STK_UNF    (STK_UNF)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   function automatic logic [ADDR_W-1:0] modelTop();
      if (mStk.size() == 0) return '0;
      return mStk[mStk.size()-1];
   endfunction

   task automatic modelReset();
      mPc = 10'h000;
      mStk.delete();
      mOvf = 1'b0;
      mUnf = 1'b0;
   endtask

   task automatic compare(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput(input string tag);
      compare({tag, ".pc"},    16'(PC_COUNT),   16'(mPc));
      compare({tag, ".top"},   16'(FROM_STACK), 16'(modelTop()));
      compare({tag, ".empty"}, 16'(STK_EMPTY),  16'(mStk.size() == 0));
      compare({tag, ".full"},  16'(STK_FULL),   16'(mStk.size() == DEPTH));
      compare({tag, ".ovf"},   16'(STK_OVF),    16'(mOvf));
      compare({tag, ".unf"},   16'(STK_UNF),    16'(mUnf));
   endtask

   // Drive one clock worth of control, advance the model by the same rules,
   // then sample the DUT just after the edge.
   task automatic applyStimulus(input string tag, input logic ld, input logic inc,
                                input logic push, input logic cur, input logic pop,
                                input logic clr, input logic [ADDR_W-1:0] din);
      logic [ADDR_W-1:0] pushVal;
      logic              setOvf;
      logic              setUnf;
      PC_LD = ld; PC_INC = inc; PUSH = push; PUSH_CUR = cur;
      POP = pop; ERR_CLR = clr; D_IN = din;
      pushVal = cur ? mPc : mPc + 10'd1;
      setOvf = 1'b0;
      setUnf = 1'b0;
      if (push && pop) begin
         if (mStk.size() > 0) mStk[mStk.size()-1] = pushVal;
         else mStk.push_back(pushVal);
      end else if (push) begin
         if (mStk.size() < DEPTH) mStk.push_back(pushVal);
         else setOvf = 1'b1;
      end else if (pop) begin
         if (mStk.size() > 0) void'(mStk.pop_back());
         else setUnf = 1'b1;
      end
      if (clr) begin
         mOvf = 1'b0;
         mUnf = 1'b0;
      end
      if (setOvf) mOvf = 1'b1;
      if (setUnf) mUnf = 1'b1;
      if (ld) mPc = din;
      else if (inc) mPc = mPc + 10'd1;
      @(posedge CLK);
      #1;
      checkOutput(tag);
   endtask

   initial begin
      logic [ADDR_W-1:0] topBefore;
      RST_N = 1'b0;
      D_IN = '0; PC_LD = 0; PC_INC = 0; PUSH = 0; PUSH_CUR = 0; POP = 0; ERR_CLR = 0;
      modelReset();
      #12;
      checkOutput("reset");
      @(negedge CLK);
      RST_N = 1'b1;

      // Counting up from the reset vector
      for (int i = 0; i < 3; i++) applyStimulus("inc", 0, 1, 0, 0, 0, 0, 10'h000);

      // Asynchronous reset in the middle of a cycle
      #2;
      RST_N = 1'b0;
      #1;
      modelReset();
      compare("async_rst.pc", 16'(PC_COUNT), 16'h000);
      checkOutput("async_rst");
      @(negedge CLK);
      RST_N = 1'b1;

      // CALL then RET
      applyStimulus("ld120",   1, 0, 0, 0, 0, 0, 10'h120);
      applyStimulus("call",    1, 0, 1, 0, 0, 0, 10'h050);
      compare("call.top121", 16'(FROM_STACK), 16'h121);
      applyStimulus("ret",     1, 0, 0, 0, 1, 0, modelTop());
      compare("ret.pc121", 16'(PC_COUNT), 16'h121);

      // Wrap of PC and of the pushed return address
      applyStimulus("ld3ff",   1, 0, 0, 0, 0, 0, 10'h3FF);
      applyStimulus("incwrap", 0, 1, 0, 0, 0, 0, 10'h000);
      applyStimulus("ld3ffb",  1, 0, 0, 0, 0, 0, 10'h3FF);
      applyStimulus("pushwrap", 0, 0, 1, 0, 0, 0, 10'h000);
      compare("pushwrap.top000", 16'(FROM_STACK), 16'h000);
      applyStimulus("popwrap", 0, 0, 0, 0, 1, 0, 10'h000);

      // Fill, overflow, drain, underflow, clear
      for (int i = 0; i < DEPTH; i++)
         applyStimulus("fill", 1, 0, 1, 0, 0, 0, 10'(16 * (i + 1)));
      topBefore = modelTop();
      applyStimulus("ovf", 1, 0, 1, 0, 0, 0, 10'h2AA);
      compare("ovf.topkept", 16'(FROM_STACK), 16'(topBefore));
      for (int i = 0; i < DEPTH + 1; i++)
         applyStimulus("drain", 1, 0, 0, 0, 1, 0, modelTop());
      applyStimulus("unf_setwins", 0, 0, 0, 0, 1, 1, 10'h000);
      applyStimulus("errclr", 0, 0, 0, 0, 0, 1, 10'h000);

      // Nested CALL then interrupt
      applyStimulus("ld010",  1, 0, 0, 0, 0, 0, 10'h010);
      applyStimulus("call2",  1, 0, 1, 0, 0, 0, 10'h020);
      applyStimulus("intr",   1, 0, 1, 1, 0, 0, rat_pkg::INTR_VEC);
      compare("intr.top020", 16'(FROM_STACK), 16'h020);
      applyStimulus("reti",   1, 0, 0, 0, 1, 0, modelTop());
      compare("reti.top011", 16'(FROM_STACK), 16'h011);
      applyStimulus("ret2",   1, 0, 0, 0, 1, 0, modelTop());

      // Simultaneous push and pop
      applyStimulus("ld050",  1, 0, 0, 0, 0, 0, 10'h050);
      applyStimulus("pcur",   1, 0, 1, 1, 0, 0, 10'h010);
      applyStimulus("pnext",  1, 0, 1, 0, 0, 0, 10'h200);
      compare("pnext.top011", 16'(FROM_STACK), 16'h011);
      applyStimulus("swap",   0, 0, 1, 0, 1, 0, 10'h000);
      compare("swap.top201", 16'(FROM_STACK), 16'h201);
      applyStimulus("pop1",   0, 0, 0, 0, 1, 0, 10'h000);
      applyStimulus("pop2",   0, 0, 0, 0, 1, 0, 10'h000);
      applyStimulus("swapempty", 0, 0, 1, 0, 1, 0, 10'h000);
      compare("swapempty.unf", 16'(STK_UNF), 16'h0);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         applyStimulus("rand",
                       ($urandom_range(3) == 0), ($urandom_range(1) == 1),
                       ($urandom_range(2) == 0), ($urandom_range(1) == 1),
                       ($urandom_range(2) == 0), ($urandom_range(7) == 0),
                       10'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
